// File: rtl/amiga_a1000_pkg.sv
// Shared definitions for the A1000 boot-ROM / WOM controller: address map,
// region codes and the bus-cycle FSM states.
package amiga_a1000_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_ROM     = 3'd2,
    ST_RAS     = 3'd3,
    ST_CAS     = 3'd4,
    ST_ACK     = 3'd5,
    ST_WAITEND = 3'd6,
    ST_PRECH   = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    RGN_NONE = 2'd0,
    RGN_ROM  = 2'd1,
    RGN_WOM  = 2'd2
  } region_e;

  // All regions are 256 KiB, so one mask serves every base.
  localparam logic [23:0] REGION_MASK = 24'hFC0000;
  localparam logic [23:0] ROM_BASE    = 24'hF80000;
  localparam logic [23:0] OVL_BASE    = 24'h000000;
  localparam logic [23:0] WOM_BASE    = 24'hFC0000;

  function automatic region_e decode_region(input logic [23:1] a, input logic ovl);
    logic [23:0] addr;
    addr = {a, 1'b0};
    if ((addr & REGION_MASK) == WOM_BASE) return RGN_WOM;
    if ((addr & REGION_MASK) == ROM_BASE) return RGN_ROM;
    if (ovl && ((addr & REGION_MASK) == OVL_BASE)) return RGN_ROM;
    return RGN_NONE;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, with a selectable
// reset value so idle-high strobes come out of reset deasserted.
module sync_2ff #(
  parameter int                 WIDTH   = 1,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/amiga_a1000_wom_ctrl.sv
// A1000 bus-cycle controller: decodes 68000 cycles into boot-ROM and
// write-once-memory (WOM) DRAM accesses, generates _DTACK and the WOM lock.
module amiga_a1000_wom_ctrl
  import amiga_a1000_pkg::*;
#(
  parameter int ROM_WAIT  = 6,
  parameter int CAS_DLY   = 2,
  parameter int PRECHARGE = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [23:1] A,
  input  logic        _AS,
  input  logic        _UDS,
  input  logic        _LDS,
  input  logic        _PRW,
  input  logic        OVL,
  inout  wire         _DTACK,
  output logic        _ROME,
  output logic        _WOM_RAS,
  output logic        _WOM_CASU,
  output logic        _WOM_CASL,
  output logic        _WOM_WE,
  output logic        LOCK,
  output state_e      dbg_state_o
);

  localparam int            CNT_W    = 8;
  localparam logic [CNT_W-1:0] ROM_ACK = CNT_W'(ROM_WAIT - 1);
  localparam logic [CNT_W-1:0] CAS_AT  = CNT_W'(CAS_DLY);
  localparam logic [CNT_W-1:0] PRE_END = CNT_W'(PRECHARGE - 1);

  logic [2:0] sync_q;
  logic       as_s;
  logic       uds_s;
  logic       lds_s;

  sync_2ff #(
    .WIDTH   (3),
    .RST_VAL (3'b111)
  ) u_sync (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   ({_AS, _UDS, _LDS}),
    .q_o   (sync_q)
  );

  assign as_s  = sync_q[2];
  assign uds_s = sync_q[1];
  assign lds_s = sync_q[0];

  state_e           state_q;
  region_e          region_q;
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] pc_q;
  logic             wr_q;
  logic             discard_q;
  logic             lock_q;
  logic             rome_n_q;
  logic             ras_n_q;
  logic             casu_n_q;
  logic             casl_n_q;
  logic             we_n_q;
  logic             dtack_q;

  logic             bus_busy;
  logic             ras_open;

  assign bus_busy = state_q inside {ST_DECODE, ST_ROM, ST_RAS, ST_CAS, ST_ACK, ST_WAITEND};
  assign ras_open = state_q inside {ST_RAS, ST_CAS, ST_ACK};

  // cyc_q counts edges since cycle 0, so on edge k it holds k-1.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      region_q  <= RGN_NONE;
      cyc_q     <= '0;
      pc_q      <= '0;
      wr_q      <= 1'b0;
      discard_q <= 1'b0;
      lock_q    <= 1'b0;
      rome_n_q  <= 1'b1;
      ras_n_q   <= 1'b1;
      casu_n_q  <= 1'b1;
      casl_n_q  <= 1'b1;
      we_n_q    <= 1'b1;
      dtack_q   <= 1'b0;
    end else begin
      if (state_q != ST_IDLE && cyc_q != '1) begin
        cyc_q <= cyc_q + 1'b1;
      end

      if (as_s && bus_busy) begin
        // End of cycle (normal or aborted): everything releases together.
        rome_n_q  <= 1'b1;
        ras_n_q   <= 1'b1;
        casu_n_q  <= 1'b1;
        casl_n_q  <= 1'b1;
        we_n_q    <= 1'b1;
        dtack_q   <= 1'b0;
        discard_q <= 1'b0;
        pc_q      <= '0;
        state_q   <= ras_open ? ST_PRECH : ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (!as_s) begin
              state_q   <= ST_DECODE;
              cyc_q     <= '0;
              region_q  <= decode_region(A, OVL);
              wr_q      <= !_PRW;
              discard_q <= 1'b0;
            end
          end

          ST_DECODE: begin
            case (region_q)
              RGN_ROM: begin
                state_q <= ST_ROM;
                if (wr_q) begin
                  lock_q <= 1'b1;
                end else begin
                  rome_n_q <= 1'b0;
                end
              end
              RGN_WOM: begin
                if (wr_q && lock_q) begin
                  state_q   <= ST_WAITEND;
                  discard_q <= 1'b1;
                end else begin
                  state_q <= ST_RAS;
                  ras_n_q <= 1'b0;
                end
              end
              default: state_q <= ST_WAITEND;
            endcase
          end

          ST_ROM: begin
            if (cyc_q >= ROM_ACK) begin
              dtack_q <= 1'b1;
            end
          end

          ST_RAS: begin
            // Writes also wait for a data strobe so CAS never latches stale data.
            if (cyc_q >= CAS_AT && (!wr_q || !uds_s || !lds_s)) begin
              state_q  <= ST_CAS;
              casu_n_q <= uds_s;
              casl_n_q <= lds_s;
              we_n_q   <= !wr_q;
            end
          end

          ST_CAS: begin
            state_q <= ST_ACK;
            dtack_q <= 1'b1;
          end

          ST_ACK: begin
            dtack_q <= 1'b1;
          end

          ST_WAITEND: begin
            // Locked WOM writes are acknowledged and dropped; unmapped cycles never are.
            if (discard_q && cyc_q >= 8'd1) begin
              dtack_q <= 1'b1;
            end
          end

          ST_PRECH: begin
            if (pc_q >= PRE_END) begin
              state_q <= ST_IDLE;
            end else begin
              pc_q <= pc_q + 1'b1;
            end
          end

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign _DTACK      = dtack_q ? 1'b0 : 1'bz;
  assign _ROME       = rome_n_q;
  assign _WOM_RAS    = ras_n_q;
  assign _WOM_CASU   = casu_n_q;
  assign _WOM_CASL   = casl_n_q;
  assign _WOM_WE     = we_n_q;
  assign LOCK        = lock_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_amiga_a1000_wom_ctrl.sv
// Directed bench for the A1000 ROM/WOM controller: cycle-exact strobe,
// _DTACK, LOCK and FSM-state checks against hand-computed values.
module tb_amiga_a1000_wom_ctrl;
  import amiga_a1000_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:1] a = '0;
  logic        as_n = 1'b1;
  logic        uds_n = 1'b1;
  logic        lds_n = 1'b1;
  logic        prw = 1'b1;
  logic        ovl = 1'b1;
  wire         dtack_w;
  logic        rome_n;
  logic        ras_n;
  logic        casu_n;
  logic        casl_n;
  logic        we_n;
  logic        lock;
  state_e      dbg_state;

  int errors = 0;
  int checks = 0;

  pullup (dtack_w);

  amiga_a1000_wom_ctrl #(
    .ROM_WAIT  (6),
    .CAS_DLY   (2),
    .PRECHARGE (2)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .A           (a),
    ._AS         (as_n),
    ._UDS        (uds_n),
    ._LDS        (lds_n),
    ._PRW        (prw),
    .OVL         (ovl),
    ._DTACK      (dtack_w),
    ._ROME       (rome_n),
    ._WOM_RAS    (ras_n),
    ._WOM_CASU   (casu_n),
    ._WOM_CASL   (casl_n),
    ._WOM_WE     (we_n),
    .LOCK        (lock),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bit order: {_ROME, _WOM_RAS, _WOM_CASU, _WOM_CASL, _WOM_WE, _DTACK}
  function automatic logic [7:0] strb();
    return {2'b00, rome_n, ras_n, casu_n, casl_n, we_n, dtack_w};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input state_e exp);
    chk(tag, 8'(dbg_state), 8'(exp));
  endtask

  task automatic start_cycle(input logic [23:0] addr, input logic rd,
                             input logic u_n, input logic l_n);
    a     = addr[23:1];
    prw   = rd;
    uds_n = u_n;
    lds_n = l_n;
    as_n  = 1'b0;
  endtask

  task automatic end_cycle();
    as_n  = 1'b1;
    uds_n = 1'b1;
    lds_n = 1'b1;
  endtask

  initial begin
    // Reset state
    tick(2);
    chk("rst_strb", strb(), 8'b00111111);
    chk("rst_lock", {7'b0, lock}, 8'd0);
    chk_st("rst_state", ST_IDLE);
    rst = 1'b0;
    tick(1);

    // Overlay read of $000000: ROM from cycle 1, _DTACK at cycle 6
    start_cycle(24'h000000, 1'b1, 1'b0, 1'b0);
    tick(3);
    chk_st("ovl_c0", ST_DECODE);
    tick(1);
    chk("ovl_c1", strb(), 8'b00011111);
    tick(4);
    chk("ovl_c5", strb(), 8'b00011111);
    tick(1);
    chk("ovl_c6", strb(), 8'b00011110);
    end_cycle();
    tick(2);
    chk("ovl_hold", strb(), 8'b00011110);
    tick(1);
    chk("ovl_rel", strb(), 8'b00111111);
    chk_st("ovl_idle", ST_IDLE);

    // Unlocked WOM write $FC0000, both strobes
    ovl = 1'b0;
    start_cycle(24'hFC0000, 1'b0, 1'b0, 1'b0);
    tick(3);
    chk_st("wr_c0", ST_DECODE);
    tick(1);
    chk("wr_c1", strb(), 8'b00101111);
    tick(1);
    chk("wr_c2", strb(), 8'b00101111);
    tick(1);
    chk("wr_c3", strb(), 8'b00100001);
    tick(1);
    chk("wr_c4", strb(), 8'b00100000);
    end_cycle();
    tick(3);
    chk("wr_rel", strb(), 8'b00111111);
    chk_st("wr_prech", ST_PRECH);
    tick(1);
    chk("wr_prech_ras", strb(), 8'b00111111);
    chk_st("wr_prech2", ST_PRECH);
    tick(1);
    chk_st("wr_idle", ST_IDLE);

    // ROM write sets LOCK, _ROME stays high, _DTACK at cycle 6
    start_cycle(24'hF80000, 1'b0, 1'b0, 1'b0);
    tick(4);
    chk("lk_c1", strb(), 8'b00111111);
    chk("lk_lock", {7'b0, lock}, 8'd1);
    chk_st("lk_state", ST_ROM);
    tick(5);
    chk("lk_c6", strb(), 8'b00111110);
    end_cycle();
    tick(3);
    chk("lk_rel", strb(), 8'b00111111);
    chk_st("lk_idle", ST_IDLE);

    // Locked WOM write: _DTACK at cycle 2, no DRAM strobes
    start_cycle(24'hFC0000, 1'b0, 1'b0, 1'b0);
    tick(4);
    chk_st("lw_c1", ST_WAITEND);
    chk("lw_c1_strb", strb(), 8'b00111111);
    tick(1);
    chk("lw_c2", strb(), 8'b00111110);
    end_cycle();
    tick(3);
    chk("lw_rel", strb(), 8'b00111111);
    chk_st("lw_idle", ST_IDLE);

    // WOM read while locked proceeds normally
    start_cycle(24'hFC0000, 1'b1, 1'b0, 1'b0);
    tick(4);
    chk("rd_c1", strb(), 8'b00101111);
    tick(2);
    chk("rd_c3", strb(), 8'b00100011);
    tick(1);
    chk("rd_c4", strb(), 8'b00100010);
    end_cycle();
    tick(3);
    chk("rd_rel", strb(), 8'b00111111);
    tick(2);
    chk_st("rd_idle", ST_IDLE);

    // Unmapped read $E00000: nothing driven, back to IDLE
    start_cycle(24'hE00000, 1'b1, 1'b0, 1'b0);
    tick(4);
    chk_st("nm_c1", ST_WAITEND);
    tick(7);
    chk("nm_c8", strb(), 8'b00111111);
    end_cycle();
    tick(3);
    chk("nm_rel", strb(), 8'b00111111);
    chk_st("nm_idle", ST_IDLE);

    // LDS-only read $FC0002, then back-to-back _AS during precharge
    start_cycle(24'hFC0002, 1'b1, 1'b1, 1'b0);
    tick(6);
    chk("ld_c3", strb(), 8'b00101011);
    tick(1);
    chk("ld_c4", strb(), 8'b00101010);
    end_cycle();
    tick(3);
    chk("ld_rel", strb(), 8'b00111111);
    chk_st("ld_prech", ST_PRECH);
    start_cycle(24'hFC0000, 1'b1, 1'b0, 1'b0);
    tick(3);
    chk_st("b2b_c0", ST_DECODE);
    chk("b2b_c0_ras", strb(), 8'b00111111);
    tick(1);
    chk("b2b_c1", strb(), 8'b00101111);
    tick(3);
    chk("b2b_c4", strb(), 8'b00100010);
    end_cycle();
    tick(5);
    chk_st("b2b_idle", ST_IDLE);

    // Reset during CAS with LOCK set
    start_cycle(24'hFC0000, 1'b1, 1'b0, 1'b0);
    tick(6);
    chk_st("rc_c3", ST_CAS);
    chk("rc_lock", {7'b0, lock}, 8'd1);
    rst = 1'b1;
    end_cycle();
    tick(1);
    chk("rc_strb", strb(), 8'b00111111);
    chk("rc_lock0", {7'b0, lock}, 8'd0);
    chk_st("rc_idle", ST_IDLE);
    rst = 1'b0;
    tick(3);

    // Aborted WOM read: _AS high before _DTACK
    start_cycle(24'hFC0000, 1'b1, 1'b0, 1'b0);
    tick(4);
    end_cycle();
    tick(2);
    chk_st("ab_c3", ST_CAS);
    chk("ab_c3_strb", strb(), 8'b00100011);
    tick(1);
    chk("ab_c4", strb(), 8'b00111111);
    chk_st("ab_prech", ST_PRECH);
    tick(2);
    chk_st("ab_idle", ST_IDLE);

    // Unlocked WOM write with late _UDS: CAS waits for the data strobe
    start_cycle(24'hFC0000, 1'b0, 1'b1, 1'b1);
    tick(6);
    chk_st("dw_c3", ST_RAS);
    chk("dw_c3_strb", strb(), 8'b00101111);
    uds_n = 1'b0;
    tick(2);
    chk_st("dw_c5", ST_RAS);
    tick(1);
    chk("dw_c6", strb(), 8'b00100101);
    tick(1);
    chk("dw_c7", strb(), 8'b00100100);
    chk("dw_lock", {7'b0, lock}, 8'd0);
    end_cycle();
    tick(3);
    chk("dw_rel", strb(), 8'b00111111);
    tick(2);
    chk_st("dw_idle", ST_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/amiga_a1000_wom_ctrl.md
AMIGA_A1000_WOM_CTRL -- requirements
Module: amiga_a1000_wom_ctrl

Interface
REQ-001 Parameter ROM_WAIT, default 6: CLK cycles from decode to _DTACK for boot-ROM cycles.
REQ-002 Parameter CAS_DLY, default 2: CLK cycles from _WOM_RAS assertion to _WOM_CAS assertion.
REQ-003 Parameter PRECHARGE, default 2: minimum CLK cycles with _WOM_RAS high between WOM cycles.
REQ-004 CLK  in  1  28.63636 MHz master clock; only clock.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 A  in  23  CPU address A[23:1].
REQ-007 _AS, _UDS, _LDS, _PRW  in  1 each  68000 strobes and read/write (1=read); asynchronous to CLK.
REQ-008 OVL  in  1  overlay; 1 maps $000000-$03FFFF to the boot ROM.
REQ-009 _DTACK  inout  1  open-drain: drives 0 when asserted, z otherwise.
REQ-010 _ROME  out  1  boot-ROM chip enable, active low.
REQ-011 _WOM_RAS, _WOM_CASU, _WOM_CASL, _WOM_WE  out  1 each  WOM DRAM strobes, active low.
REQ-012 LOCK  out  1  WOM write-protect status.

Function
REQ-013 _AS, _UDS, _LDS SHALL pass through 2-FF synchronizers; all timing below counts from the first CLK edge where synchronized _AS is low (cycle 0).
REQ-014 Decode at cycle 0 with A latched at that edge: ROM = $F80000-$FBFFFF, or $000000-$03FFFF when OVL=1; WOM = $FC0000-$FFFFFF; anything else = NONE.
REQ-015 FSM states: IDLE, DECODE, ROM, RAS, CAS, ACK, WAITEND, PRECH.
REQ-016 IDLE->DECODE on synchronized _AS low; DECODE->ROM, RAS or WAITEND (NONE, or a write to WOM while LOCK=1).
REQ-017 ROM: _ROME low from cycle 1; _DTACK low at cycle ROM_WAIT for reads. A write to the ROM region SHALL set LOCK, SHALL keep _ROME high and SHALL still assert _DTACK at cycle ROM_WAIT.
REQ-018 RAS: _WOM_RAS low from cycle 1. A read enters CAS after CAS_DLY cycles. A write enters CAS after CAS_DLY cycles and after synchronized _UDS or _LDS is low, whichever is later.
REQ-019 CAS: _WOM_CASU follows synchronized _UDS and _WOM_CASL follows synchronized _LDS, both latched on CAS entry; _WOM_WE = _PRW latched at DECODE. _DTACK is asserted one cycle after CAS entry (state ACK).
REQ-020 ACK/ROM hold all strobes and _DTACK until synchronized _AS is high, then release all outputs in the same cycle; WOM cycles go to PRECH, ROM cycles go to IDLE.
REQ-021 PRECH holds _WOM_RAS high for PRECHARGE cycles and then returns to IDLE; an _AS low edge seen during PRECH SHALL wait (it is not lost).
REQ-022 WAITEND drives no outputs and no _DTACK; it returns to IDLE when synchronized _AS is high.
REQ-023 A write to WOM while LOCK=1 SHALL assert _DTACK at cycle 2 with no DRAM strobes (write silently discarded).
REQ-024 _AS going high before _DTACK (aborted cycle) SHALL release all strobes next cycle; WOM cycles still pass through PRECH.
REQ-025 LOCK is sticky; only RST clears it.

Reset
REQ-026 On RST: FSM=IDLE; LOCK=0; _ROME, _WOM_RAS, _WOM_CASU, _WOM_CASL, _WOM_WE =1; _DTACK=z; synchronizers loaded with 1.
REQ-027 RST mid-cycle SHALL release all strobes on the next edge regardless of state; there is no precharge guarantee across reset.

Structure
REQ-028 Region base/mask constants and the FSM state enum SHALL live in package amiga_a1000_pkg.
REQ-029 Synchronizer SHALL be sub-module sync_2ff (parameterized width), instantiated once for 3 bits.

Verification
REQ-030 OVL=1, read $000000 -> _ROME low from cycle 1, _DTACK low at cycle 6, released 1 cycle after _AS high; no WOM strobes.
REQ-031 OVL=0, LOCK=0, write $FC0000 with both strobes -> _WOM_RAS at cycle 1, CASU/CASL at cycle 3, _WOM_WE low, _DTACK at cycle 4; then RAS high for 2 cycles minimum.
REQ-032 Write $F80000 -> LOCK=1, _DTACK at cycle 6, _ROME stays high; a following write to $FC0000 -> _DTACK at cycle 2, no strobes; a read of $FC0000 -> normal WOM read.
REQ-033 Read $E00000 -> no _DTACK and no strobes; FSM back in IDLE after _AS high.
REQ-034 Read $FC0002 with only _LDS -> only _WOM_CASL low; back-to-back _AS during PRECH -> next RAS not earlier than 2 cycles after release.
REQ-035 RST pulsed during CAS with LOCK=1 -> all strobes high next cycle, LOCK=0, _DTACK=z.
